// File: rtl/mux_arbiter.sv
// Two-channel show-ahead FIFO arbiter: bounded bursts per channel, pause
// back-pressure, and a post-reset idle handshake before the first grant.
`timescale 1ns/1ps
module mux_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int IDLE_SYNC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in_0,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_1,
  input  logic [7:0] data_in_1,
  input  logic       pause,
  output logic       grant_0,
  output logic       grant_1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active_ch
);

  localparam int         DATA_W   = 8;
  localparam logic [3:0] BMAX     = 4'(BURST_MAX);
  localparam logic [7:0] IDLE_TGT = 8'(IDLE_SYNC);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    SEND0 = 2'd2,
    SEND1 = 2'd3
  } state_t;

  state_t              state_q;
  logic [7:0]          idle_cnt_q;
  logic [3:0]          burst_cnt_q;
  logic                active_ch_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                valid_out_q;

  logic                gnt0_d;
  logic                gnt1_d;
  logic                extend_d;
  logic [7:0]          idle_cnt_d;

  // Grant decision: same-channel continuation wins until the burst limit,
  // then the other requester; a lone requester at the limit restarts its burst.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (!pause) begin
      case (state_q)
        IDLE: begin
          if (valid_in_0 && valid_in_1) begin
            gnt0_d = active_ch_q;
            gnt1_d = !active_ch_q;
          end else begin
            gnt0_d = valid_in_0;
            gnt1_d = valid_in_1;
          end
        end
        SEND0: begin
          if (valid_in_0 && (burst_cnt_q < BMAX)) gnt0_d = 1'b1;
          else if (valid_in_1)                    gnt1_d = 1'b1;
          else if (valid_in_0)                    gnt0_d = 1'b1;
        end
        SEND1: begin
          if (valid_in_1 && (burst_cnt_q < BMAX)) gnt1_d = 1'b1;
          else if (valid_in_0)                    gnt0_d = 1'b1;
          else if (valid_in_1)                    gnt1_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign extend_d   = (((state_q == SEND0) && gnt0_d) || ((state_q == SEND1) && gnt1_d))
                      && (burst_cnt_q < BMAX);
  assign idle_cnt_d = idle_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC;
      idle_cnt_q  <= 8'd0;
      burst_cnt_q <= 4'd0;
      active_ch_q <= 1'b1;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= gnt0_d | gnt1_d;
      data_out_q  <= gnt0_d ? data_in_0 : (gnt1_d ? data_in_1 : 8'h00);
      case (state_q)
        SYNC: begin
          if (valid_in_0 || valid_in_1) begin
            idle_cnt_q <= 8'd0;
          end else if (idle_cnt_d >= IDLE_TGT) begin
            idle_cnt_q <= 8'd0;
            state_q    <= IDLE;
          end else begin
            idle_cnt_q <= idle_cnt_d;
          end
        end
        default: begin
          if (!pause) begin
            if (gnt0_d || gnt1_d) begin
              state_q     <= gnt0_d ? SEND0 : SEND1;
              active_ch_q <= gnt1_d;
              burst_cnt_q <= extend_d ? burst_cnt_q + 4'd1 : 4'd1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign grant_0   = gnt0_d;
  assign grant_1   = gnt1_d;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign active_ch = active_ch_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: upstream FIFOs as queues, a rule-level
// arbitration model checked every cycle, plus hand-computed output sequences.
`timescale 1ns/1ps
module tb_mux_arbiter;
  localparam int BM    = 4;
  localparam int ISYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       v0, v1, pause;
  logic [7:0] d0, d1;
  logic       g0, g1, vout, act;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;

  mux_arbiter #(.BURST_MAX(BM), .IDLE_SYNC(ISYNC)) dut (
    .clk(clk), .reset(reset),
    .valid_in_0(v0), .data_in_0(d0),
    .valid_in_1(v1), .data_in_1(d1),
    .pause(pause),
    .grant_0(g0), .grant_1(g1),
    .data_out(dout), .valid_out(vout), .active_ch(act)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Rule-level model: syncing flag, owner of current/last burst, run length (0 = not in a burst)
  bit         m_sync;
  int         m_idle, m_own, m_run;
  logic [7:0] m_dout;
  bit         m_vout;

  function automatic int pick();
    logic [1:0] v;
    int own, oth;
    v   = {v1, v0};
    own = m_own;
    oth = 1 - own;
    if (m_sync || pause) return -1;
    if (m_run > 0 && v[own] && m_run < BM) return own;
    if (v[oth]) return oth;
    if (v[own]) return own;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sync <= 1'b1; m_idle <= 0; m_own <= 1; m_run <= 0;
      m_dout <= 8'h00; m_vout <= 1'b0;
    end else begin
      m_vout <= (pick() >= 0);
      m_dout <= (pick() == 0) ? d0 : ((pick() == 1) ? d1 : 8'h00);
      if (m_sync) begin
        if (v0 || v1) m_idle <= 0;
        else if (m_idle + 1 >= ISYNC) begin m_sync <= 1'b0; m_idle <= 0; end
        else m_idle <= m_idle + 1;
      end else if (!pause) begin
        if (pick() < 0) m_run <= 0;
        else if (pick() == m_own && m_run > 0) m_run <= (m_run % BM) + 1;
        else begin m_run <= 1; m_own <= pick(); end
      end
    end
  end

  logic [8:0] outlog[$];
  logic [8:0] expq[$];
  bit         log_en = 1'b0;
  int         gcnt0 = 0, gcnt1 = 0;

  always @(negedge clk) begin
    if (!reset) begin
      check("grant_0", int'(g0), int'(pick() == 0));
      check("grant_1", int'(g1), int'(pick() == 1));
      check("one_grant", int'(g0 & g1), 0);
      check("valid_out", int'(vout), int'(m_vout));
      check("data_out", int'(dout), int'(m_dout));
      check("active_ch", int'(act), m_own);
      if (log_en) begin
        outlog.push_back({vout, dout});
        if (g0) gcnt0++;
        if (g1) gcnt1++;
      end
    end
  end

  logic [7:0] q0[$], q1[$];

  task automatic apply();
    v0 = (q0.size() > 0);
    d0 = v0 ? q0[0] : 8'h00;
    v1 = (q1.size() > 0);
    d1 = v1 ? q1[0] : 8'h00;
  endtask

  task automatic step();
    bit p0, p1;
    @(negedge clk);
    p0 = g0;
    p1 = g1;
    @(posedge clk);
    #2;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    apply();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 80 && (q0.size() > 0 || q1.size() > 0); n++) step();
    check({name, "_drained"}, q0.size() + q1.size(), 0);
    step();
    step();
  endtask

  task automatic cmp_log(input string name);
    int first;
    first = -1;
    for (int i = 0; i < outlog.size(); i++)
      if (outlog[i][8] && first < 0) first = i;
    check({name, "_any_output"}, int'(first >= 0), 1);
    if (first < 0) first = 0;
    for (int i = 0; i < expq.size(); i++) begin
      int idx;
      idx = first + i;
      check($sformatf("%s[%0d]", name, i),
            (idx < outlog.size()) ? int'(outlog[idx]) : 32'h1FFF, int'(expq[i]));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    q0.delete();
    q1.delete();
    pause = 1'b0;
    apply();
    @(posedge clk);
    #2 reset = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    #3;
    check("rst_data_out", int'(dout), 0);
    check("rst_valid_out", int'(vout), 0);
    check("rst_active_ch", int'(act), 1);
    check("rst_grant_0", int'(g0), 0);
    check("rst_grant_1", int'(g1), 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // first word after two idle cycles
    step();
    step();
    q0.push_back(8'hA1);
    apply();
    #2 check("first_grant_0", int'(g0), 1);
    step();
    #2;
    check("first_data_out", int'(dout), 8'hA1);
    check("first_valid_out", int'(vout), 1);

    // both channels loaded with ten words
    do_reset();
    outlog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'hA0 + 8'(i));
      q1.push_back(8'hB0 + 8'(i));
    end
    apply();
    drain("dual");
    log_en = 1'b0;
    expq.delete();
    for (int i = 0; i < 4; i++)  expq.push_back({1'b1, 8'hA0 + 8'(i)});
    for (int i = 0; i < 4; i++)  expq.push_back({1'b1, 8'hB0 + 8'(i)});
    for (int i = 4; i < 8; i++)  expq.push_back({1'b1, 8'hA0 + 8'(i)});
    for (int i = 4; i < 8; i++)  expq.push_back({1'b1, 8'hB0 + 8'(i)});
    expq.push_back(9'h1A8); expq.push_back(9'h1A9);
    expq.push_back(9'h1B8); expq.push_back(9'h1B9);
    expq.push_back(9'h000);
    cmp_log("dual");

    // lone requester wraps its burst without bubbles
    outlog.delete();
    gcnt0 = 0;
    log_en = 1'b1;
    for (int i = 0; i < 9; i++) q1.push_back(8'hC0 + 8'(i));
    apply();
    drain("solo");
    log_en = 1'b0;
    expq.delete();
    for (int i = 0; i < 9; i++) expq.push_back({1'b1, 8'hC0 + 8'(i)});
    expq.push_back(9'h000);
    cmp_log("solo");
    check("solo_no_grant_0", gcnt0, 0);

    // pause for three cycles mid-burst
    outlog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(8'hD0 + 8'(i));
      q1.push_back(8'hE0 + 8'(i));
    end
    apply();
    step();
    step();
    pause = 1'b1;
    step();
    step();
    step();
    pause = 1'b0;
    drain("pause");
    log_en = 1'b0;
    expq.delete();
    expq.push_back(9'h1D0); expq.push_back(9'h1D1);
    expq.push_back(9'h000); expq.push_back(9'h000); expq.push_back(9'h000);
    expq.push_back(9'h1D2); expq.push_back(9'h1D3);
    for (int i = 0; i < 4; i++) expq.push_back({1'b1, 8'hE0 + 8'(i)});
    expq.push_back(9'h1D4); expq.push_back(9'h1D5);
    expq.push_back(9'h1E4); expq.push_back(9'h1E5);
    cmp_log("pause");

    // asynchronous reset mid-burst, then resync with valid held high
    for (int i = 0; i < 6; i++) q0.push_back(8'hF0 + 8'(i));
    apply();
    step();
    step();
    check("mid_pre_valid_out", int'(vout), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid_out", int'(vout), 0);
    check("mid_rst_data_out", int'(dout), 0);
    check("mid_rst_active_ch", int'(act), 1);
    check("mid_rst_grant_0", int'(g0), 0);
    check("mid_rst_grant_1", int'(g1), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    apply();
    gcnt0 = 0;
    gcnt1 = 0;
    log_en = 1'b1;
    repeat (5) step();
    log_en = 1'b0;
    check("resync_no_grant", gcnt0 + gcnt1, 0);
    q0.delete();
    apply();
    step();
    step();
    q0.push_back(8'h5A);
    apply();
    #2 check("resync_grant_0", int'(g0), 1);
    step();
    #2;
    check("resync_data_out", int'(dout), 8'h5A);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
